// File: rtl/poci_gpio_n.sv
// poci_gpio_n: WIDTH-pin GPIO on the POCI (APB-style) bus.
// Per-pin direction, atomic set/clear/toggle of the output register,
// a SYNC_STAGES-deep input synchroniser, and rise/fall edge detection
// with sticky W1C status feeding one level interrupt.
module poci_gpio_n #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      io_bus_paddr,
  input  logic             io_bus_pwrite,
  input  logic             io_bus_psel,
  input  logic             io_bus_penable,
  input  logic [31:0]      io_bus_pwdata,
  output logic [31:0]      io_bus_prdata,
  output logic             io_bus_pready,
  output logic             io_bus_pslverr,
  input  logic [WIDTH-1:0] io_pin_i,
  output logic [WIDTH-1:0] io_pin_o,
  output logic [WIDTH-1:0] io_pin_oe,
  output logic             io_irq
);

  // The detector stays disarmed until the synchroniser and prev flop have
  // been refilled with real pin values after reset.
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  localparam logic [3:0] A_OUT      = 4'd0;
  localparam logic [3:0] A_IN       = 4'd1;
  localparam logic [3:0] A_DIR      = 4'd2;
  localparam logic [3:0] A_OUT_SET  = 4'd3;
  localparam logic [3:0] A_OUT_CLR  = 4'd4;
  localparam logic [3:0] A_OUT_TGL  = 4'd5;
  localparam logic [3:0] A_RISE_EN  = 4'd6;
  localparam logic [3:0] A_FALL_EN  = 4'd7;
  localparam logic [3:0] A_IRQ_STAT = 4'd8;
  localparam logic [3:0] A_IRQ_MASK = 4'd9;

  logic             acc;
  logic             wr;
  logic [3:0]       addr;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] irq_stat_q;
  logic [WIDTH-1:0] irq_mask_q;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_now;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] event_set;
  logic [WIDTH-1:0] stat_w1c;

  logic [ARM_W-1:0] arm_cnt;
  logic             armed;

  logic [WIDTH-1:0] rd_val;
  logic [31:0]      rd_word;

  // Address bits outside [5:2] and write data above WIDTH are don't-care.
  logic [59:0]      bus_unused;
  assign bus_unused = {io_bus_paddr[31:6], io_bus_paddr[1:0], io_bus_pwdata};

  assign acc   = io_bus_psel & io_bus_penable;
  assign wr    = acc & io_bus_pwrite;
  assign addr  = io_bus_paddr[5:2];
  assign wdata = io_bus_pwdata[WIDTH-1:0];

  // Output data register, including the atomic set/clear/toggle aliases.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
    end else if (wr) begin
      case (addr)
        A_OUT:     out_q <= wdata;
        A_OUT_SET: out_q <= out_q | wdata;
        A_OUT_CLR: out_q <= out_q & ~wdata;
        A_OUT_TGL: out_q <= out_q ^ wdata;
        default:   ;
      endcase
    end
  end

  // Plain read/write configuration registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_mask_q <= '0;
    end else if (wr) begin
      case (addr)
        A_DIR:      dir_q      <= wdata;
        A_RISE_EN:  rise_en_q  <= wdata;
        A_FALL_EN:  fall_en_q  <= wdata;
        A_IRQ_MASK: irq_mask_q <= wdata;
        default:    ;
      endcase
    end
  end

  // Input synchroniser chain followed by the prev flop used for edge detect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= io_pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_now;
    end
  end

  // Post-reset arming counter; saturates at its terminal count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  assign armed     = (arm_cnt == ARM_W'(ARM_CYCLES));
  assign sync_now  = sync_q[SYNC_STAGES-1];
  assign rise      = sync_now & ~prev_q;
  assign fall      = ~sync_now & prev_q;
  assign event_set = {WIDTH{armed}} & ((rise & rise_en_q) | (fall & fall_en_q));
  assign stat_w1c  = (wr && (addr == A_IRQ_STAT)) ? wdata : '0;

  // Sticky edge status; a new event beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_stat_q <= '0;
    end else begin
      irq_stat_q <= (irq_stat_q & ~stat_w1c) | event_set;
    end
  end

  // Read mux; write-only aliases and unmapped slots read as zero.
  always_comb begin
    rd_val = '0;
    case (addr)
      A_OUT:      rd_val = out_q;
      A_IN:       rd_val = sync_now;
      A_DIR:      rd_val = dir_q;
      A_RISE_EN:  rd_val = rise_en_q;
      A_FALL_EN:  rd_val = fall_en_q;
      A_IRQ_STAT: rd_val = irq_stat_q;
      A_IRQ_MASK: rd_val = irq_mask_q;
      default:    rd_val = '0;
    endcase
  end

  // Zero-extend the selected register to the bus width.
  always_comb begin
    rd_word = '0;
    rd_word[WIDTH-1:0] = rd_val;
  end

  assign io_bus_prdata  = acc ? rd_word : 32'd0;
  assign io_bus_pready  = 1'b1;
  assign io_bus_pslverr = acc & (addr > A_IRQ_MASK);

  assign io_pin_o  = out_q;
  assign io_pin_oe = dir_q;
  assign io_irq    = |(irq_stat_q & irq_mask_q);

endmodule

// File: tb/tb_poci_gpio_n.sv
// Scoreboard bench for poci_gpio_n (WIDTH=8, SYNC_STAGES=2).
// Stimulus pushes expectations; a negedge monitor pops them whenever a
// read access phase or a signal-observation strobe is present.
`timescale 1ns/1ps
module tb_poci_gpio_n;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   paddr = '0;
  logic          pwrite = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic [31:0]   pwdata = '0;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic [W-1:0]  pin_i = '0;
  logic [W-1:0]  pin_o;
  logic [W-1:0]  pin_oe;
  logic          irq;

  poci_gpio_n #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .io_bus_paddr   (paddr),
    .io_bus_pwrite  (pwrite),
    .io_bus_psel    (psel),
    .io_bus_penable (penable),
    .io_bus_pwdata  (pwdata),
    .io_bus_prdata  (prdata),
    .io_bus_pready  (pready),
    .io_bus_pslverr (pslverr),
    .io_pin_i       (pin_i),
    .io_pin_o       (pin_o),
    .io_pin_oe      (pin_oe),
    .io_irq         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    string       name;
    logic [31:0] exp;
    logic        exp_err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic obs_on   = 1'b0;
  int   obs_sel  = 0;   // 0 pin_o, 1 pin_oe, 2 irq, 3 pready

  localparam int S_PIN_O = 0, S_PIN_OE = 1, S_IRQ = 2, S_PREADY = 3;

  // Advance one cycle; the bus returns to idle and strobes drop.
  task automatic tick();
    @(posedge clk); #1;
    obs_on  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Full two-phase write; returns just after the commit edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    tick();
    psel = 1'b1; pwrite = 1'b1; paddr = {26'd0, a, 2'b00}; pwdata = d; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    tick();
  endtask

  // Single-cycle write: access phase in the current cycle, commits next edge.
  task automatic poke(input logic [3:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = {26'd0, a, 2'b00}; pwdata = d;
  endtask

  task automatic push_read(input string nm, input logic [31:0] e, input logic err);
    exp_t x;
    x.is_read = 1'b1; x.name = nm; x.exp = e; x.exp_err = err;
    sb.push_back(x);
  endtask

  // Full two-phase read; checked by the monitor during the access phase.
  task automatic bus_read(input logic [3:0] a, input string nm, input logic [31:0] e,
                          input logic err);
    tick();
    psel = 1'b1; pwrite = 1'b0; paddr = {26'd0, a, 2'b00}; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    push_read(nm, e, err);
  endtask

  // Zero-wait read in the current cycle, for exact-latency checks.
  task automatic peek(input logic [3:0] a, input string nm, input logic [31:0] e);
    push_read(nm, e, 1'b0);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = {26'd0, a, 2'b00};
  endtask

  task automatic observe(input string nm, input int sel, input logic [31:0] e);
    exp_t x;
    x.is_read = 1'b0; x.name = nm; x.exp = e; x.exp_err = 1'b0;
    sb.push_back(x);
    obs_sel = sel;
    obs_on  = 1'b1;
  endtask

  // Monitor: pops one expectation per presented output.
  initial begin
    exp_t        e;
    logic [31:0] v;
    forever begin
      @(negedge clk);
      if (psel && penable && !pwrite) begin
        n_checks++;
        if (sb.size() == 0 || !sb[0].is_read) begin
          $display("FAIL sb_read: unexpected read at paddr=%h data=%h", paddr, prdata);
          if (sb.size() != 0) void'(sb.pop_front());
        end else begin
          e = sb.pop_front();
          if (prdata === e.exp && pslverr === e.exp_err) n_pass++;
          else $display("FAIL %s: got data=%h err=%b, want data=%h err=%b",
                        e.name, prdata, pslverr, e.exp, e.exp_err);
        end
      end
      if (obs_on) begin
        n_checks++;
        case (obs_sel)
          S_PIN_O:  v = {24'd0, pin_o};
          S_PIN_OE: v = {24'd0, pin_oe};
          S_IRQ:    v = {31'd0, irq};
          default:  v = {31'd0, pready};
        endcase
        if (sb.size() == 0 || sb[0].is_read) begin
          $display("FAIL sb_obs: unexpected observation sel=%0d value=%h", obs_sel, v);
          if (sb.size() != 0) void'(sb.pop_front());
        end else begin
          e = sb.pop_front();
          if (v === e.exp) n_pass++;
          else $display("FAIL %s: got %h, want %h", e.name, v, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    ticks(2);
    observe("rst_pin_o", S_PIN_O, 32'h0);   tick();
    observe("rst_pin_oe", S_PIN_OE, 32'h0); tick();
    observe("rst_irq", S_IRQ, 32'h0);       tick();
    observe("rst_pready", S_PREADY, 32'h1); tick();
    reset = 1'b1;

    // Readback of the whole map after reset
    for (int a = 0; a < 16; a++)
      bus_read(4'(a), $sformatf("reset_rd%0d", a), 32'h0, (a > 9));

    // Upper write bits ignored; 1-cycle output latency
    bus_write(4'd0, 32'hFFFF_FFFF);
    observe("out_all_pin", S_PIN_O, 32'hFF);
    bus_read(4'd0, "out_all_rd", 32'hFF, 1'b0);

    // Atomic operations
    bus_write(4'd0, 32'h0F);
    bus_write(4'd3, 32'h30); observe("set_pin", S_PIN_O, 32'h3F);
    bus_read(4'd3, "set_reads0", 32'h0, 1'b0);
    bus_write(4'd4, 32'h05); observe("clr_pin", S_PIN_O, 32'h3A);
    bus_read(4'd4, "clr_reads0", 32'h0, 1'b0);
    bus_write(4'd5, 32'hFF); observe("tgl_pin", S_PIN_O, 32'hC5);
    bus_read(4'd5, "tgl_reads0", 32'h0, 1'b0);
    bus_read(4'd0, "tgl_rd", 32'hC5, 1'b0);
    bus_write(4'd2, 32'hA5); observe("dir_oe", S_PIN_OE, 32'hA5);
    bus_read(4'd2, "dir_rd", 32'hA5, 1'b0);
    bus_write(4'd1, 32'hFF);
    bus_read(4'd1, "in_ro", 32'h0, 1'b0);

    // Synchroniser and IRQ latency
    bus_write(4'd6, 32'h01);
    bus_write(4'd9, 32'h01);
    pin_i = 8'h01;
    tick(); peek(4'd1, "in_lat1", 32'h0);  observe("irq_lat1", S_IRQ, 32'h0);
    tick(); peek(4'd1, "in_lat2", 32'h01); observe("irq_lat2", S_IRQ, 32'h0);
    tick(); peek(4'd8, "stat_lat3", 32'h01); observe("irq_lat3", S_IRQ, 32'h1);
    bus_write(4'd8, 32'h01); observe("w1c_irq", S_IRQ, 32'h0);
    tick(); peek(4'd8, "w1c_stat", 32'h0);

    // Falling-edge-only mode on pin 1
    bus_write(4'd6, 32'h0);
    bus_write(4'd7, 32'h02);
    bus_write(4'd9, 32'h0);
    pin_i = 8'h03;
    ticks(3); peek(4'd8, "fall_norise", 32'h0);
    tick(); pin_i = 8'h01;
    ticks(2); peek(4'd8, "fall_lat2", 32'h0);
    tick();   peek(4'd8, "fall_lat3", 32'h02); observe("fall_masked", S_IRQ, 32'h0);
    bus_write(4'd9, 32'h02); observe("mask_irq_on", S_IRQ, 32'h1);
    bus_write(4'd8, 32'h02); observe("fall_w1c_irq", S_IRQ, 32'h0);

    // W1C racing a new rising edge on pin 0
    bus_write(4'd7, 32'h0);
    bus_write(4'd6, 32'h01);
    bus_write(4'd9, 32'h01);
    tick(); peek(4'd8, "race_pre", 32'h0);
    pin_i = 8'h00; ticks(4);
    pin_i = 8'h01; ticks(4);
    peek(4'd8, "race_first", 32'h01);
    tick();
    pin_i = 8'h00; ticks(4);
    pin_i = 8'h01;
    bus_write(4'd8, 32'h01);
    peek(4'd8, "race_setwins", 32'h01); observe("race_irq", S_IRQ, 32'h1);
    bus_write(4'd8, 32'h01); observe("race_clr_irq", S_IRQ, 32'h0);
    tick(); peek(4'd8, "race_clr_stat", 32'h0);

    // Arming after reset with pins held high
    pin_i = 8'hFF;
    reset = 1'b0;
    tick(); observe("rst2_pin_o", S_PIN_O, 32'h0);
    ticks(2);
    reset = 1'b1;
    poke(4'd6, 32'hFF);
    ticks(4); peek(4'd8, "arm_nostat", 32'h0);
    tick();   peek(4'd6, "arm_rise_en", 32'hFF);

    // Reset in the middle of a write clears everything
    bus_write(4'd0, 32'h5A);
    bus_write(4'd2, 32'h3C);
    bus_write(4'd7, 32'h0F);
    bus_write(4'd9, 32'hFF);
    pin_i = 8'h00;
    ticks(3); observe("pre_rst_irq", S_IRQ, 32'h1);
    tick();   peek(4'd8, "pre_rst_stat", 32'h0F);
    tick();
    psel = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFF; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    reset = 1'b0;
    tick(); observe("midrst_pin_o", S_PIN_O, 32'h0);
    tick(); observe("midrst_pin_oe", S_PIN_OE, 32'h0);
    tick(); observe("midrst_irq", S_IRQ, 32'h0);
    tick();
    reset = 1'b1;
    bus_read(4'd0, "midrst_out", 32'h0, 1'b0);
    bus_read(4'd2, "midrst_dir", 32'h0, 1'b0);
    bus_read(4'd6, "midrst_rise", 32'h0, 1'b0);
    bus_read(4'd7, "midrst_fall", 32'h0, 1'b0);
    bus_read(4'd8, "midrst_stat", 32'h0, 1'b0);
    bus_read(4'd9, "midrst_mask", 32'h0, 1'b0);
    ticks(3);

    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/poci_gpio_n.md
# poci_gpio_n

Parametrised GPIO peripheral on the POCI (APB-style) peripheral bus, successor to the fixed 4-bit GPIO. It provides:
- `WIDTH` pins with per-pin direction control;
- atomic set, clear and toggle of the output register;
- a configurable-depth input synchroniser;
- per-pin rising/falling edge detection with sticky, write-1-to-clear status and a single level interrupt to the system interrupt controller.

## Interface
Parameters:
- `WIDTH`, 4: number of GPIO pins, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..3.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `io_bus_paddr`  in  32  byte address; only [5:2] decoded.
- `io_bus_pwrite`  in  1  1 = write.
- `io_bus_psel`  in  1  slave select.
- `io_bus_penable`  in  1  access phase.
- `io_bus_pwdata`  in  32  write data; bits ≥ `WIDTH` ignored.
- `io_bus_prdata`  out  32  read data; bits ≥ `WIDTH` are 0.
- `io_bus_pready`  out  1  constant 1 (zero wait states).
- `io_bus_pslverr`  out  1  error on unmapped access.
- `io_pin_i`  in  `WIDTH`  raw asynchronous pin inputs.
- `io_pin_o`  out  `WIDTH`  output data register.
- `io_pin_oe`  out  `WIDTH`  output enable, 1 = drive.
- `io_irq`  out  1  level interrupt.

## Operation
- Access strobe `acc = psel & penable`. A write commits on the clk edge where `acc & pwrite`.
- Register map (`paddr[5:2]`):
  - 0 `OUT`: RW, output data.
  - 1 `IN`: RO, synchronised pins; writes ignored.
  - 2 `DIR`: RW, 1 = output; drives `io_pin_oe`.
  - 3 `OUT_SET`: W1S into `OUT`; reads 0.
  - 4 `OUT_CLR`: W1C into `OUT`; reads 0.
  - 5 `OUT_TGL`: write-1-toggle of `OUT`; reads 0.
  - 6 `RISE_EN`: RW, per-pin rising-edge detect enable.
  - 7 `FALL_EN`: RW, per-pin falling-edge detect enable.
  - 8 `IRQ_STAT`: R / W1C, sticky edge flags.
  - 9 `IRQ_MASK`: RW, 1 = pin contributes to `io_irq`.
  - 10–15: unmapped; reads 0, writes have no effect.
- `io_bus_pslverr = acc & (paddr[5:2] > 9)`. It is 0 whenever `acc` is 0.
- `io_bus_prdata` is combinational from the decoded register while `acc` is high, and 0 otherwise.
- `io_pin_o = OUT` regardless of `DIR`; the pad/tristate logic uses `io_pin_oe`.
- Synchroniser: `SYNC_STAGES` flops per pin, then one extra `prev` flop.
  - `rise = sync & ~prev`, `fall = ~sync & prev`.
- `IRQ_STAT[i]` sets when `armed & ((rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]))`.
- Arming: a counter holds `armed` low for `SYNC_STAGES+1` cycles after reset deasserts, so pins that are high at reset do not produce spurious rising edges. After that, `armed` stays 1 until the next reset.
- `io_irq = |(IRQ_STAT & IRQ_MASK)`, combinational from registers.
- Simultaneous events:
  - W1C of `IRQ_STAT[i]` in the same cycle that bit i sets: the set wins, and the flag stays 1.
  - `OUT_SET`, `OUT_CLR` and `OUT_TGL` each touch only their own access cycle. No two can coincide, since there is one access per cycle.
- The bus address is word-granular; `paddr[1:0]` and `paddr[31:6]` are ignored.

## Timing
- Reset (`reset == 0` at a clk edge) clears all of the following to 0: `OUT`, `DIR`, `RISE_EN`, `FALL_EN`, `IRQ_STAT`, `IRQ_MASK`, synchroniser, `prev`, and the arming counter.
  - Output values in reset: `io_pin_o = 0`, `io_pin_oe = 0`, `io_irq = 0`.
  - `io_bus_prdata = 0` when idle; `io_bus_pready = 1`; `io_bus_pslverr = 0` when idle.
- Reset asserted mid-operation overrides any concurrent bus write in that cycle.
- Write to `OUT`, `DIR` or `OUT_*`: new output is visible the cycle after the write edge (1-cycle latency).
- Pin change to `IN` readback: `SYNC_STAGES` edges.
- Pin change to `IRQ_STAT` set: `SYNC_STAGES+1` edges.
- `io_irq` changes in the same cycle as `IRQ_STAT` or `IRQ_MASK`.
- Reads are zero-wait: data is valid during the access phase.
- A pin pulse shorter than one clk period may be missed; this is acceptable.
- A pulse of at least 2 clk periods produces both a rise and a fall event.

## Test plan
- **Reset/readback:** `WIDTH=8`; after reset, read all 16 addresses. Required: all 0; `pslverr=1` only at addresses 10–15. Write `0xFFFF_FFFF` to `OUT`: reads `0xFF`, `io_pin_o=0xFF` one cycle after the write.
- **Atomic ops:** from `OUT=0x0F`, write `OUT_SET=0x30` → `0x3F`; `OUT_CLR=0x05` → `0x3A`; `OUT_TGL=0xFF` → `0xC5`. Each change appears the cycle after its write edge.
- **Sync latency:** `SYNC_STAGES=2`; drive `io_pin_i=0x01`. Required: `IN` reads `0x01` after exactly 2 edges. With `RISE_EN=0x01` and `IRQ_MASK=0x01`, `IRQ_STAT=0x01` and `io_irq=1` after exactly 3 edges.
- **Edge modes:** `FALL_EN=0x02` only; pulse pin 1 high for 4 cycles. Required: no status on the rising edge; `IRQ_STAT[1]=1` 3 edges after the fall. With `IRQ_MASK=0`, `io_irq` stays 0.
- **W1C race:** write `IRQ_STAT=0x01` in the same cycle a new enabled rising edge reaches pin 0's detector. Required: bit stays 1. A later W1C with no edge clears it, and `io_irq` drops in that cycle.
- **Reset arming:** hold `io_pin_i=0xFF` through reset. Release reset, then enable `RISE_EN=0xFF` within 1 cycle. Required: `IRQ_STAT` remains 0; reassert reset mid-write → all registers 0.
